ccsds_ldpc_info_extractor: RTL and testbench
============================================

Name: ccsds_ldpc_info_extractor

Overview:
Receive-side counterpart of the CCSDS LDPC encoder. It accepts a hard-decision codeword as a 1-bit AXI-Stream and forwards only the systematic information bits on a 1-bit AXI-Stream. It discards the parity bits and checks codeword framing against the configured code length. It sits after the demodulator/hard slicer, or after a future decoder bypass, and feeds the frame sink / descrambler.

Parameters:
- stander, "8160,7136", code selection. Legal values: "8160,7136" (N=8160, K=7136) and "8176,7154" (N=8176, K=7154). Any other value is a compile-time error.
- CNT_W, 16, width of the saturating frame statistics counters.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  1  codeword bit, transmission order
- s_axis_tvalid  in  1  input bit valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last bit of codeword, as asserted by the upstream source
- m_axis_tdata  out  1  information bit
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last information bit of the frame
- m_axis_tready  in  1  downstream ready
- frame_err  out  1  one-cycle pulse on a framing error
- frames_ok  out  CNT_W  count of correctly framed codewords, saturating
- frames_bad  out  CNT_W  count of misframed codewords, saturating

Behaviour:
- Reset: all outputs are 0 and bit counter idx=0. The state is S_INFO and the skid buffer is empty. A reset asserted mid-frame drops any partial frame and buffered bits with no flush and no tlast.
- Input transfer: s_axis_tvalid & s_axis_tready on a clk edge.
- Output transfer: m_axis_tvalid & m_axis_tready on a clk edge.
- idx counts accepted input bits, 0..N-1, and returns to 0 after the frame ends.
- FSM:
  - S_INFO: the accepted bit is pushed to the output stage with tlast = (idx==K-1) or s_axis_tlast. When idx==K-1 with no input tlast, go to S_PARITY.
  - S_PARITY: bits are consumed and dropped. s_axis_tready=1 unconditionally, so parity is never stalled by the downstream. When idx==N-1 or s_axis_tlast, frame end: go to S_INFO, idx=0.
- Output stage: 2-entry skid buffer. s_axis_tready in S_INFO = not full.
  - Latency: 1 cycle from input accept to m_axis_tvalid when the buffer is empty.
  - Sustains 1 bit/clk when m_axis_tready=1.
  - m_axis_* hold stable while valid & !ready.
- Framing checks (frame_err pulses the cycle after the offending transfer; frames_bad += 1):
  - Early tlast in S_INFO (idx<K-1): the bit is forwarded with m_axis_tlast=1 and the frame ends (idx=0, stay S_INFO).
  - Early tlast in S_PARITY (idx<N-1): the frame ends.
  - Missing tlast at idx==N-1: the frame is closed anyway; the next bit starts a new frame.
- Good frame: tlast exactly at idx==N-1. frames_ok += 1 the cycle after.
- Counters saturate at 2^CNT_W-1.
- If an error and a good-frame increment would land in the same cycle, this is impossible by construction (one frame end per transfer).
- No combinational path from m_axis_tready to s_axis_tready. Ready derives from registered fill state only.

Decomposition:
- Package ccsds_ldpc_pkg holds:
  - code constants N_8160=8160, K_8160=7136, N_8176=8176, K_8176=7154;
  - a function returning N/K from stander;
  - the state encoding (S_INFO, S_PARITY);
  - idx width constant IDX_W=13.
- The encoder should share this package.
- One sub-module: axis_skid_buf_1b (2-entry, data+last), reusable across the LDPC blocks.

Test Plan:
- One 8160-bit frame (info = alternating 1/0, parity = all 1), tlast at bit 8159, m_axis_tready=1 → exactly 7136 output bits equal to input bits 0..7135. m_axis_tlast only on bit 7135, frames_ok=1, no frame_err, first output 1 cycle after first accept.
- Same frame with m_axis_tready toggled 1/0 every cycle and random tvalid gaps → identical 7136-bit output, no drops or duplicates. Stability holds under stall. Parity phase is accepted at 1 bit/clk even with m_axis_tready=0.
- tlast at input bit 99 → 100 output bits with tlast on bit 99, frame_err pulse, frames_bad=1. The next full 8160-bit frame passes cleanly (frames_ok=1).
- No tlast at bit 8159, followed by a correct frame → first frame output is still 7136 bits with tlast, frames_bad=1. The second frame aligns and frames_ok=1.
- rst asserted at input bit 3000 of a frame, then a full frame → no output bits from the aborted frame after reset, counters=0, next frame passes.
- stander="8176,7154", back-to-back 3 frames → 3×7154 info bits with 3 tlasts, frames_ok=3. Also force frames_bad past 2^CNT_W-1 with CNT_W=2 → it saturates at 3.

Source files
------------

// File: rtl/ccsds_ldpc_pkg.sv
// Shared constants, code-length lookup and state encoding for the CCSDS LDPC
// encode/extract blocks.
package ccsds_ldpc_pkg;

    localparam int unsigned N_8160    = 8160;
    localparam int unsigned K_8160    = 7136;
    localparam int unsigned N_8176    = 8176;
    localparam int unsigned K_8176    = 7154;
    localparam int unsigned IDX_W     = 13;
    localparam int unsigned STANDER_W = 72;

    typedef enum logic {
        S_INFO   = 1'b0,
        S_PARITY = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] n;
        logic [IDX_W-1:0] k;
        logic             valid;
    } code_dims_t;

    function automatic code_dims_t code_dims(input logic [STANDER_W-1:0] stander);
        code_dims_t d;
        d = '0;
        if (stander == "8160,7136") begin
            d.n     = IDX_W'(N_8160);
            d.k     = IDX_W'(K_8160);
            d.valid = 1'b1;
        end else if (stander == "8176,7154") begin
            d.n     = IDX_W'(N_8176);
            d.k     = IDX_W'(K_8176);
            d.valid = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/axis_skid_buf_1b.sv
// Two-entry skid buffer for a 1-bit AXI-Stream with tlast. Input ready comes
// only from the registered fill count, never from the downstream ready.
module axis_skid_buf_1b (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_s_tvalid,
    input  logic i_s_tdata,
    input  logic i_s_tlast,
    output logic o_s_tready,
    output logic o_m_tvalid,
    output logic o_m_tdata,
    output logic o_m_tlast,
    input  logic i_m_tready
);

    logic [1:0] r_cnt;
    logic       r_d0, r_l0, r_d1, r_l1;
    logic       w_push, w_pop;

    assign o_s_tready = (r_cnt != 2'd2);
    assign o_m_tvalid = (r_cnt != 2'd0);
    assign o_m_tdata  = r_d0;
    assign o_m_tlast  = r_l0;
    assign w_push     = i_s_tvalid && o_s_tready;
    assign w_pop      = o_m_tvalid && i_m_tready;

    // Entry 0 always feeds the output; it only changes when empty or popped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 2'd0;
            r_d0  <= 1'b0;
            r_l0  <= 1'b0;
            r_d1  <= 1'b0;
            r_l1  <= 1'b0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_d0 <= i_s_tdata;
                        r_l0 <= i_s_tlast;
                    end else begin
                        r_d1 <= i_s_tdata;
                        r_l1 <= i_s_tlast;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_l0  <= r_l1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_d0 <= i_s_tdata;
                        r_l0 <= i_s_tlast;
                    end else begin
                        r_d0 <= r_d1;
                        r_l0 <= r_l1;
                        r_d1 <= i_s_tdata;
                        r_l1 <= i_s_tlast;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ccsds_ldpc_info_extractor.sv
// Forwards the systematic bits of a hard-decision CCSDS LDPC codeword stream,
// drops parity, and checks frame alignment against the configured code length.
module ccsds_ldpc_info_extractor
    import ccsds_ldpc_pkg::*;
#(
    parameter logic [STANDER_W-1:0] stander = "8160,7136",
    parameter int unsigned          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic             m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             frame_err,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_bad
);

    localparam code_dims_t       DIMS       = code_dims(stander);
    localparam logic [IDX_W-1:0] IDX_K_LAST = DIMS.k - IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_N_LAST = DIMS.n - IDX_W'(1);

    if (!DIMS.valid) begin : g_bad_stander
        $error("ccsds_ldpc_info_extractor: stander must be \"8160,7136\" or \"8176,7154\"");
    end

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             w_s_tready, w_buf_ready;
    logic             w_push, w_push_last;
    logic             w_frame_ok, w_frame_bad;
    logic             r_frame_err;
    logic [CNT_W-1:0] r_frames_ok, r_frames_bad;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_s_tready  = 1'b1;
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_frame_ok  = 1'b0;
        w_frame_bad = 1'b0;
        unique case (r_state)
            S_INFO: begin
                w_s_tready = w_buf_ready;
                if (s_axis_tvalid && w_buf_ready) begin
                    w_push      = 1'b1;
                    w_push_last = (r_idx == IDX_K_LAST) || s_axis_tlast;
                    if (s_axis_tlast) begin
                        // Any tlast before the parity section is a short frame.
                        w_frame_bad = 1'b1;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                        if (r_idx == IDX_K_LAST) begin
                            w_state_nxt = S_PARITY;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (s_axis_tvalid) begin
                    if ((r_idx == IDX_N_LAST) || s_axis_tlast) begin
                        w_state_nxt = S_INFO;
                        w_idx_nxt   = '0;
                        if ((r_idx == IDX_N_LAST) && s_axis_tlast) begin
                            w_frame_ok = 1'b1;
                        end else begin
                            w_frame_bad = 1'b1;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_INFO;
            r_idx        <= '0;
            r_frame_err  <= 1'b0;
            r_frames_ok  <= '0;
            r_frames_bad <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_frame_err <= w_frame_bad;
            if (w_frame_ok && (r_frames_ok != '1)) begin
                r_frames_ok <= r_frames_ok + 1'b1;
            end
            if (w_frame_bad && (r_frames_bad != '1)) begin
                r_frames_bad <= r_frames_bad + 1'b1;
            end
        end
    end

    axis_skid_buf_1b u_skid (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_s_tvalid (w_push),
        .i_s_tdata  (s_axis_tdata),
        .i_s_tlast  (w_push_last),
        .o_s_tready (w_buf_ready),
        .o_m_tvalid (m_axis_tvalid),
        .o_m_tdata  (m_axis_tdata),
        .o_m_tlast  (m_axis_tlast),
        .i_m_tready (m_axis_tready)
    );

    assign s_axis_tready = w_s_tready;
    assign frame_err     = r_frame_err;
    assign frames_ok     = r_frames_ok;
    assign frames_bad    = r_frames_bad;

endmodule

// File: tb/tb_ccsds_ldpc_info_extractor.sv
// Bench for ccsds_ldpc_info_extractor: directed frames, a vector table and
// randomized traffic against a frame-position reference model.
module tb_ccsds_ldpc_info_extractor;

    localparam int N0 = 8160;
    localparam int K0 = 7136;
    localparam int N1 = 8176;
    localparam int K1 = 7154;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DUT A: 8160/7136, 16-bit counters ----------------
    logic        a_rst = 1'b1, a_s_tdata = 1'b0, a_s_tvalid = 1'b0, a_s_tlast = 1'b0;
    logic        a_s_tready, a_m_tdata, a_m_tvalid, a_m_tlast, a_err;
    logic        a_m_tready = 1'b1;
    logic [15:0] a_ok, a_bad;

    ccsds_ldpc_info_extractor #(.stander("8160,7136"), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
        .s_axis_tlast(a_s_tlast),
        .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tlast(a_m_tlast),
        .m_axis_tready(a_m_tready),
        .frame_err(a_err), .frames_ok(a_ok), .frames_bad(a_bad)
    );

    // ---------------- DUT B: 8176/7154, 2-bit counters ----------------
    logic       b_rst = 1'b1, b_s_tdata = 1'b0, b_s_tvalid = 1'b0, b_s_tlast = 1'b0;
    logic       b_s_tready, b_m_tdata, b_m_tvalid, b_m_tlast, b_err;
    logic       b_m_tready = 1'b1;
    logic [1:0] b_ok, b_bad;

    ccsds_ldpc_info_extractor #(.stander("8176,7154"), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
        .s_axis_tlast(b_s_tlast),
        .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tlast(b_m_tlast),
        .m_axis_tready(b_m_tready),
        .frame_err(b_err), .frames_ok(b_ok), .frames_bad(b_bad)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- A monitor: ready pattern, capture, stability ----------------
    int rmode = 0;  // 0 always ready, 1 toggle, 2 random
    bit got_d[$], got_l[$];
    int err_pulses = 0, unstable = 0, first_valid_cyc = -1;
    bit prev_stall = 0, prev_d = 0, prev_l = 0;

    always @(negedge clk) begin
        if (prev_stall && !(a_m_tvalid && a_m_tdata == prev_d && a_m_tlast == prev_l)) unstable++;
        if (rmode == 0)      a_m_tready = 1'b1;
        else if (rmode == 1) a_m_tready = ~a_m_tready;
        else                 a_m_tready = ($urandom_range(0, 1) == 1);
        if (a_m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (a_m_tvalid && a_m_tready) begin
            got_d.push_back(a_m_tdata);
            got_l.push_back(a_m_tlast);
        end
        prev_stall = a_m_tvalid && !a_m_tready;
        prev_d     = a_m_tdata;
        prev_l     = a_m_tlast;
        if (a_err) err_pulses++;
    end

    // ---------------- A stimulus and reference model ----------------
    bit in_d[$], in_l[$];
    bit exp_d[$], exp_l[$];
    int exp_ok, exp_bad, base_ok, base_bad;
    int first_accept_cyc = -1, parity_stalls = 0;

    task automatic begin_scn();
        @(negedge clk);
        #2;
        in_d.delete(); in_l.delete(); got_d.delete(); got_l.delete();
        err_pulses = 0; unstable = 0; parity_stalls = 0;
        first_accept_cyc = -1; first_valid_cyc = -1;
        base_ok = int'(a_ok); base_bad = int'(a_bad);
    endtask

    // Info bits alternate 1/0 starting with 1; parity bits are all 1.
    task automatic add_frame(input int nbits, input int tlast_at, input int k);
        for (int i = 0; i < nbits; i++) begin
            in_d.push_back((i < k) ? ((i % 2) == 0) : 1'b1);
            in_l.push_back(i == tlast_at);
        end
    endtask

    task automatic drive_a(input int gap_pct);
        for (int i = 0; i < in_d.size(); i++) begin
            int waited = 0;
            bit done = 0;
            while (!done) begin
                @(negedge clk);
                a_s_tvalid = ($urandom_range(0, 99) >= gap_pct);
                a_s_tdata  = in_d[i];
                a_s_tlast  = in_l[i];
                #1;
                if (a_s_tvalid && a_s_tready) begin
                    done = 1;
                    if (first_accept_cyc < 0) first_accept_cyc = cyc;
                end else begin
                    if (a_s_tvalid && i >= K0 && i < N0) parity_stalls++;
                    waited++;
                    if (waited > 200) begin
                        check("a_accept_timeout", waited, 0);
                        a_s_tvalid = 0;
                        return;
                    end
                end
            end
        end
        @(negedge clk);
        a_s_tvalid = 0;
        a_s_tlast  = 0;
    endtask

    // Expected output derived from each bit's position inside its frame.
    function automatic void model(input int n, input int k);
        int p = 0;
        exp_d.delete(); exp_l.delete(); exp_ok = 0; exp_bad = 0;
        foreach (in_d[i]) begin
            if (p < k) begin
                exp_d.push_back(in_d[i]);
                exp_l.push_back(in_l[i] || (p == k - 1));
            end
            if (in_l[i] || p == n - 1) begin
                if (in_l[i] && p == n - 1) exp_ok++;
                else exp_bad++;
                p = 0;
            end else begin
                p++;
            end
        end
    endfunction

    task automatic drain(input int n_exp);
        int w = 0;
        while (got_d.size() < n_exp && w < 40000) begin
            @(negedge clk);
            w++;
        end
        if (got_d.size() < n_exp) check("a_drain_timeout", got_d.size(), n_exp);
        repeat (8) @(negedge clk);
        #2;
    endtask

    task automatic cmp_out(input string tag);
        int bad_bits = 0;
        check({tag, "_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++)
            if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) bad_bits++;
        check({tag, "_bits"}, bad_bits, 0);
        check({tag, "_ok"}, int'(a_ok) - base_ok, exp_ok);
        check({tag, "_bad"}, int'(a_bad) - base_bad, exp_bad);
        check({tag, "_errpulse"}, err_pulses, exp_bad);
    endtask

    typedef struct {
        int nbits;
        int tlast_at;
        int exp_out;
        int exp_ok;
        int exp_bad;
    } vec_t;

    // ---------------- B: back-to-back frames and counter saturation ----------------
    bit b_got_d[$], b_got_l[$], b_exp_d[$], b_exp_l[$];
    bit b_done = 0;

    always @(negedge clk) begin
        if (b_m_tvalid && b_m_tready) begin
            b_got_d.push_back(b_m_tdata);
            b_got_l.push_back(b_m_tlast);
        end
    end

    task automatic drive_b(input bit d, input bit l);
        int w = 0;
        forever begin
            @(negedge clk);
            b_s_tvalid = 1; b_s_tdata = d; b_s_tlast = l;
            #1;
            if (b_s_tready) break;
            w++;
            if (w > 100) begin
                check("b_accept_timeout", w, 0);
                break;
            end
        end
    endtask

    initial begin
        int bad_bits, nlast;
        repeat (3) @(negedge clk);
        b_rst = 0;
        #2;
        check("b_rst_ok", int'(b_ok), 0);
        check("b_rst_bad", int'(b_bad), 0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N1; i++) begin
                bit d;
                d = 1'($urandom_range(0, 1));
                if (i < K1) begin
                    b_exp_d.push_back(d);
                    b_exp_l.push_back(i == K1 - 1);
                end
                drive_b(d, i == N1 - 1);
            end
        end
        @(negedge clk);
        b_s_tvalid = 0; b_s_tlast = 0;
        repeat (10) @(negedge clk);
        #2;
        bad_bits = 0; nlast = 0;
        for (int i = 0; i < b_got_d.size() && i < b_exp_d.size(); i++)
            if (b_got_d[i] != b_exp_d[i] || b_got_l[i] != b_exp_l[i]) bad_bits++;
        foreach (b_got_l[i]) if (b_got_l[i]) nlast++;
        check("b_count", b_got_d.size(), 3 * K1);
        check("b_bits", bad_bits, 0);
        check("b_tlasts", nlast, 3);
        check("b_ok3", int'(b_ok), 3);
        check("b_bad0", int'(b_bad), 0);
        for (int s = 0; s < 3; s++) drive_b(1'b1, 1'b1);
        @(negedge clk);
        b_s_tvalid = 0; b_s_tlast = 0;
        repeat (3) @(negedge clk);
        #2;
        check("b_bad_at_max", int'(b_bad), 3);
        for (int s = 0; s < 2; s++) drive_b(1'b0, 1'b1);
        @(negedge clk);
        b_s_tvalid = 0; b_s_tlast = 0;
        repeat (3) @(negedge clk);
        #2;
        check("b_bad_saturated", int'(b_bad), 3);
        check("b_ok_after_bad", int'(b_ok), 3);
        b_done = 1;
    end

    // ---------------- main sequence for DUT A ----------------
    initial begin
        vec_t vecs[5];
        vecs[0] = '{1,    0,    1,    0, 1};
        vecs[1] = '{2,    1,    2,    0, 1};
        vecs[2] = '{100,  99,   100,  0, 1};
        vecs[3] = '{7136, 7135, 7136, 0, 1};
        vecs[4] = '{8001, 8000, 7136, 0, 1};

        repeat (3) @(negedge clk);
        a_rst = 0;
        #2;
        check("rst_tvalid", a_m_tvalid, 0);
        check("rst_tdata", a_m_tdata, 0);
        check("rst_tlast", a_m_tlast, 0);
        check("rst_err", a_err, 0);
        check("rst_ok", int'(a_ok), 0);
        check("rst_bad", int'(a_bad), 0);
        check("rst_sready", a_s_tready, 1);

        // Clean frame, always-ready sink.
        rmode = 0;
        begin_scn();
        add_frame(N0, N0 - 1, K0);
        drive_a(0);
        drain(K0);
        model(N0, K0);
        cmp_out("t1");
        check("t1_count_const", got_d.size(), K0);
        check("t1_ok_const", int'(a_ok), 1);
        check("t1_latency", first_valid_cyc - first_accept_cyc, 1);

        // Table of tlast placements.
        for (int t = 0; t < 5; t++) begin
            begin_scn();
            add_frame(vecs[t].nbits, vecs[t].tlast_at, K0);
            drive_a(0);
            drain(vecs[t].exp_out);
            exp_d.delete(); exp_l.delete();
            for (int i = 0; i < vecs[t].exp_out; i++) begin
                exp_d.push_back(in_d[i]);
                exp_l.push_back(i == vecs[t].exp_out - 1);
            end
            exp_ok  = vecs[t].exp_ok;
            exp_bad = vecs[t].exp_bad;
            cmp_out($sformatf("vec%0d", t));
        end

        // Full frame with toggling sink ready and input gaps.
        rmode = 1;
        begin_scn();
        add_frame(N0, N0 - 1, K0);
        drive_a(25);
        drain(K0);
        model(N0, K0);
        cmp_out("t2");
        check("t2_stable", unstable, 0);
        check("t2_parity_stalls", parity_stalls, 0);
        rmode = 0;

        // Missing tlast, then an aligned frame.
        begin_scn();
        add_frame(N0, -1, K0);
        add_frame(N0, N0 - 1, K0);
        drive_a(0);
        drain(2 * K0);
        model(N0, K0);
        cmp_out("t4");
        check("t4_bad_const", int'(a_bad) - base_bad, 1);
        check("t4_ok_const", int'(a_ok) - base_ok, 1);

        // Reset mid-frame, then a clean frame.
        begin_scn();
        add_frame(3000, -1, K0);
        drive_a(0);
        @(negedge clk);
        a_rst = 1;
        repeat (2) @(negedge clk);
        a_rst = 0;
        #2;
        got_d.delete(); got_l.delete();
        check("t5_tvalid", a_m_tvalid, 0);
        check("t5_ok", int'(a_ok), 0);
        check("t5_bad", int'(a_bad), 0);
        check("t5_err", a_err, 0);
        repeat (5) @(negedge clk);
        #2;
        check("t5_no_stale", got_d.size(), 0);
        begin_scn();
        add_frame(N0, N0 - 1, K0);
        drive_a(0);
        drain(K0);
        model(N0, K0);
        cmp_out("t5_next");
        check("t5_ok_abs", int'(a_ok), 1);

        // Random short frames with random data, gaps and sink stalls.
        rmode = 2;
        begin_scn();
        for (int f = 0; f < 15; f++) begin
            int len;
            len = $urandom_range(1, 300);
            for (int i = 0; i < len; i++) begin
                in_d.push_back(1'($urandom_range(0, 1)));
                in_l.push_back(i == len - 1);
            end
        end
        drive_a(20);
        model(N0, K0);
        drain(exp_d.size());
        cmp_out("rand");
        check("rand_stable", unstable, 0);
        rmode = 0;

        begin
            int w = 0;
            while (!b_done && w < 100000) begin
                @(negedge clk);
                w++;
            end
            if (!b_done) check("b_done_timeout", 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
